// File: rtl/mult_arb_pkg.sv
// Shared constants and helpers for the shared-multiplier arbiter.
package mult_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_W     = 4;

    // Minimum of one bit so single-value fields still get a legal width.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/mult_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module mult_rr_picker
    import mult_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int ID_W  = clog2(DEF_N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  id
);

    logic [2*N_REQ-1:0] dbl;
    logic [2*N_REQ-1:0] masked;
    logic               found;
    int                 sel;

    // Upper copy stays unmasked so the search wraps past the last requester.
    always_comb begin
        dbl    = {req, req};
        masked = '0;
        found  = 1'b0;
        sel    = 0;
        gnt    = '0;
        id     = '0;
        for (int j = 0; j < 2*N_REQ; j++) begin
            masked[j] = dbl[j] & (j >= int'(ptr));
        end
        for (int j = 0; j < 2*N_REQ; j++) begin
            if (masked[j] && !found) begin
                found = 1'b1;
                sel   = (j >= N_REQ) ? j - N_REQ : j;
            end
        end
        if (found) begin
            gnt[sel] = 1'b1;
            id       = ID_W'(sel);
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin shared shift-add multiplier; MULT_ARB_ZERO_SKIP_EN ends CALC once B runs out of ones.
// state | meaning
// IDLE  | waiting for a request; arbitrates and captures operands
// CALC  | one shift-add iteration per cycle
// DONE  | result presented; pointer advances past the served requester
module mult_share_arbiter
    import mult_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int W     = DEF_W
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [N_REQ-1:0]          i_req,
    input  logic [N_REQ*W-1:0]        i_a,
    input  logic [N_REQ*W-1:0]        i_b,
    output logic [N_REQ-1:0]          o_gnt,
    output logic                      o_busy,
    output logic                      o_valid,
    output logic [clog2(N_REQ)-1:0]   o_id,
    output logic [2*W-1:0]            o_p
);

    localparam int ID_W  = clog2(N_REQ);
    localparam int CNT_W = clog2(W);

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        CALC = ST_CALC,
        DONE = ST_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [ID_W-1:0]    ptr, gnt_id, pick_id;
    logic [N_REQ-1:0]   pick_gnt;
    logic [W-1:0]       op_a, op_b, b_sh;
    logic [2*W-1:0]     a_reg, acc, acc_sum;
    logic [CNT_W-1:0]   cnt;
    logic               calc_last;

    mult_rr_picker #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_picker (
        .req (i_req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .id  (pick_id)
    );

    always_comb begin
        op_a      = i_a[pick_id*W +: W];
        op_b      = i_b[pick_id*W +: W];
        acc_sum   = acc + (b_sh[0] ? a_reg : '0);
`ifdef MULT_ARB_ZERO_SKIP_EN
        calc_last = (cnt == CNT_W'(W-1)) || ((b_sh >> 1) == '0);
`else
        calc_last = (cnt == CNT_W'(W-1));
`endif
        state_nxt = state;
        case (state)
            IDLE:    if (|i_req) state_nxt = CALC;
            CALC:    if (calc_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            gnt_id  <= '0;
            a_reg   <= '0;
            b_sh    <= '0;
            acc     <= '0;
            cnt     <= '0;
            o_gnt   <= '0;
            o_busy  <= 1'b0;
            o_valid <= 1'b0;
            o_id    <= '0;
            o_p     <= '0;
        end else begin
            state   <= state_nxt;
            o_busy  <= (state_nxt != IDLE);
            o_gnt   <= '0;
            o_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (|i_req) begin
                        o_gnt  <= pick_gnt;
                        gnt_id <= pick_id;
                        a_reg  <= {{W{1'b0}}, op_a};
                        b_sh   <= op_b;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                CALC: begin
                    acc   <= acc_sum;
                    a_reg <= a_reg << 1;
                    b_sh  <= b_sh >> 1;
                    cnt   <= cnt + 1'b1;
                    if (calc_last) begin
                        o_valid <= 1'b1;
                        o_p     <= acc_sum;
                        o_id    <= gnt_id;
                    end
                end
                DONE: begin
                    if (gnt_id == ID_W'(N_REQ-1)) ptr <= '0;
                    else                          ptr <= gnt_id + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
